// File: rtl/bus_arbiter.sv
// Round-robin req/ack arbiter sharing one slave port between N_MST masters.
// Optional per-state wait timeout is compiled in with `define ARB_TIMEOUT_EN.
module bus_arbiter #(
  parameter int N_MST   = 4,
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 15
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_MST-1:0]         want,
  input  logic [N_MST-1:0]         m_req,
  input  logic [N_MST*AW-1:0]      m_addr,
  input  logic [N_MST*DW-1:0]      m_data,
  input  logic [N_MST-1:0]         m_cmd,
  output logic [N_MST-1:0]         grant,
  output logic [N_MST-1:0]         m_ack,
  output logic [DW-1:0]            m_rdata,
  output logic                     s_req,
  output logic [AW-1:0]            s_addr,
  output logic [DW-1:0]            s_data,
  output logic                     s_cmd,
  input  logic                     s_ack,
  input  logic [DW-1:0]            s_rdata,
  output logic [$clog2(N_MST)-1:0] owner,
  output logic                     busy,
  output logic                     err
);

  localparam int PW = $clog2(N_MST);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    XFER    = 2'd2,
    RELEASE = 2'd3
  } state_t;

  if (N_MST < 2 || N_MST > 8 || TIMEOUT < 1 || TIMEOUT > 255) begin : g_param_check
    $error("bus_arbiter: N_MST must be 2..8 and TIMEOUT 1..255");
  end

  state_t           state, state_nxt;
  logic [PW-1:0]    ptr, ptr_nxt;
  logic [PW-1:0]    owner_nxt, owner_inc, pick;
  logic             found;
  logic [N_MST-1:0] grant_nxt, m_ack_nxt;
  logic [DW-1:0]    m_rdata_nxt, s_data_nxt;
  logic [AW-1:0]    s_addr_nxt;
  logic             s_req_nxt, s_cmd_nxt, err_nxt;
  logic             timed_out;

`ifdef ARB_TIMEOUT_EN
  logic [7:0] wait_cnt;

  // Counter restarts whenever the FSM changes state, so each wait state gets a full budget.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      wait_cnt <= '0;
    else if (state_nxt != state)
      wait_cnt <= '0;
    else if (state == GRANT || state == XFER)
      wait_cnt <= wait_cnt + 8'd1;
  end

  assign timed_out = (state == GRANT || state == XFER) && (wait_cnt == 8'(TIMEOUT - 1));
`else
  assign timed_out = 1'b0;
`endif

  // Lowest rotation distance from ptr wins; scanning downward lets the nearest overwrite.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    for (int k = N_MST - 1; k >= 0; k--) begin
      if (want[(int'(ptr) + k) % N_MST]) begin
        found = 1'b1;
        pick  = PW'((int'(ptr) + k) % N_MST);
      end
    end
  end

  assign owner_inc = (owner == PW'(N_MST - 1)) ? '0 : owner + 1'b1;

  always_comb begin
    state_nxt   = state;
    ptr_nxt     = ptr;
    owner_nxt   = owner;
    grant_nxt   = grant;
    m_ack_nxt   = m_ack;
    m_rdata_nxt = m_rdata;
    s_req_nxt   = s_req;
    s_addr_nxt  = s_addr;
    s_data_nxt  = s_data;
    s_cmd_nxt   = s_cmd;
    err_nxt     = 1'b0;

    case (state)
      IDLE: begin
        if (found) begin
          owner_nxt       = pick;
          grant_nxt       = '0;
          grant_nxt[pick] = 1'b1;
          state_nxt       = GRANT;
        end
      end

      GRANT: begin
        if (m_req[owner]) begin
          s_addr_nxt = m_addr[owner*AW +: AW];
          s_data_nxt = m_data[owner*DW +: DW];
          s_cmd_nxt  = m_cmd[owner];
          s_req_nxt  = 1'b1;
          state_nxt  = XFER;
        end else if (!want[owner]) begin
          grant_nxt = '0;
          ptr_nxt   = owner_inc;
          state_nxt = IDLE;
        end else if (timed_out) begin
          grant_nxt = '0;
          m_ack_nxt = '0;
          s_req_nxt = 1'b0;
          err_nxt   = 1'b1;
          ptr_nxt   = owner_inc;
          state_nxt = IDLE;
        end
      end

      XFER: begin
        if (s_ack) begin
          s_req_nxt   = 1'b0;
          m_ack_nxt   = grant;
          m_rdata_nxt = s_rdata;
          state_nxt   = RELEASE;
        end else if (timed_out) begin
          grant_nxt = '0;
          m_ack_nxt = '0;
          s_req_nxt = 1'b0;
          err_nxt   = 1'b1;
          ptr_nxt   = owner_inc;
          state_nxt = IDLE;
        end
      end

      RELEASE: begin
        if (!m_req[owner]) begin
          m_ack_nxt = '0;
          grant_nxt = '0;
          ptr_nxt   = owner_inc;
          state_nxt = IDLE;
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

  // Every output is a flop; busy is registered from the next state so it lines up with grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      ptr     <= '0;
      owner   <= '0;
      grant   <= '0;
      m_ack   <= '0;
      m_rdata <= '0;
      s_req   <= 1'b0;
      s_addr  <= '0;
      s_data  <= '0;
      s_cmd   <= 1'b0;
      busy    <= 1'b0;
      err     <= 1'b0;
    end else begin
      state   <= state_nxt;
      ptr     <= ptr_nxt;
      owner   <= owner_nxt;
      grant   <= grant_nxt;
      m_ack   <= m_ack_nxt;
      m_rdata <= m_rdata_nxt;
      s_req   <= s_req_nxt;
      s_addr  <= s_addr_nxt;
      s_data  <= s_data_nxt;
      s_cmd   <= s_cmd_nxt;
      busy    <= (state_nxt != IDLE);
      err     <= err_nxt;
    end
  end

  a_grant_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(grant));
  a_ack_owner:    assert property (@(posedge clk) disable iff (!rst_n) (m_ack & ~grant) == '0);
  a_req_granted:  assert property (@(posedge clk) disable iff (!rst_n) s_req |-> (grant != '0));

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed self-checking bench for bus_arbiter (4 masters, 32-bit bus, TIMEOUT 15).
// Timeout behaviour is checked in whichever form ARB_TIMEOUT_EN selects.
module tb_bus_arbiter;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [N-1:0]  want, m_req, m_cmd;
  logic [N*AW-1:0] m_addr;
  logic [N*DW-1:0] m_data;
  logic [N-1:0]  grant, m_ack;
  logic [DW-1:0] m_rdata, s_data, s_rdata;
  logic [AW-1:0] s_addr;
  logic          s_req, s_cmd, s_ack, busy, err;
  logic [1:0]    owner;

  int n_vec = 0;
  int n_err = 0;

  bus_arbiter #(.N_MST(N), .AW(AW), .DW(DW), .TIMEOUT(15)) dut (
    .clk(clk), .rst_n(rst_n), .want(want), .m_req(m_req), .m_addr(m_addr),
    .m_data(m_data), .m_cmd(m_cmd), .grant(grant), .m_ack(m_ack), .m_rdata(m_rdata),
    .s_req(s_req), .s_addr(s_addr), .s_data(s_data), .s_cmd(s_cmd), .s_ack(s_ack),
    .s_rdata(s_rdata), .owner(owner), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; want = '0; m_req = '0; m_cmd = '0; m_addr = '0; m_data = '0;
    s_ack = 1'b0; s_rdata = '0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic set_master(input int i, input logic [31:0] a, input logic [31:0] d, input logic c);
    m_addr[i*AW +: AW] = a;
    m_data[i*DW +: DW] = d;
    m_cmd[i] = c;
  endtask

  // Drives one complete transfer for an already-granted master, reporting what was seen.
  task automatic run_xfer(input int i, input logic [31:0] rdata,
                          output logic [31:0] sa, output logic sc, output logic sr,
                          output logic [3:0] ack, output logic [31:0] rd);
    m_req[i] = 1'b1;
    step();
    sa = s_addr; sc = s_cmd; sr = s_req;
    s_ack = 1'b1; s_rdata = rdata;
    step();
    ack = m_ack; rd = m_rdata;
    s_ack = 1'b0; m_req[i] = 1'b0;
    step();
  endtask

  task automatic test_reset();
    logic [31:0] sa, rd;
    logic sc, sr;
    logic [3:0] ack;
    do_reset();
    n_vec++; if (grant !== 4'b0) begin n_err++; $display("[TB] FAIL rst_grant: got %b expected 0000", grant); end
    n_vec++; if ({s_req, s_cmd, busy, err} !== 4'b0) begin n_err++; $display("[TB] FAIL rst_flags: got %b expected 0000", {s_req, s_cmd, busy, err}); end
    n_vec++; if ({m_ack, owner} !== 6'b0) begin n_err++; $display("[TB] FAIL rst_ack_owner: got %b expected 000000", {m_ack, owner}); end
    n_vec++; if ({s_addr, s_data, m_rdata} !== 96'b0) begin n_err++; $display("[TB] FAIL rst_data: got %h expected 0", {s_addr, s_data, m_rdata}); end
    // complete one transfer on m1 so the pointer moves away from 0
    want = 4'b0010;
    step();
    n_vec++; if (grant !== 4'b0010) begin n_err++; $display("[TB] FAIL rst_pre_grant: got %b expected 0010", grant); end
    set_master(1, 32'h44, 32'h0, 1'b0);
    run_xfer(1, 32'h1, sa, sc, sr, ack, rd);
    want = 4'b0100;
    step();
    n_vec++; if (grant !== 4'b0100) begin n_err++; $display("[TB] FAIL rst_pre_grant2: got %b expected 0100", grant); end
    m_req[2] = 1'b1;
    step();
    n_vec++; if (s_req !== 1'b1) begin n_err++; $display("[TB] FAIL rst_in_xfer: got %b expected 1", s_req); end
    rst_n = 1'b0;
    step();
    rst_n = 1'b1; m_req = '0; want = 4'b0110;
    n_vec++; if ({grant, s_req, busy, m_ack} !== 10'b0) begin n_err++; $display("[TB] FAIL rst_mid_xfer: got %b expected 0", {grant, s_req, busy, m_ack}); end
    step();
    n_vec++; if (grant !== 4'b0010) begin n_err++; $display("[TB] FAIL rst_ptr_zero: got %b expected 0010", grant); end
  endtask

  task automatic test_single_read();
    do_reset();
    want = 4'b0001;
    step();
    n_vec++; if ({grant, owner, busy} !== {4'b0001, 2'd0, 1'b1}) begin n_err++; $display("[TB] FAIL rd_grant: got %b expected 0001001", {grant, owner, busy}); end
    set_master(0, 32'h10, 32'h0, 1'b0);
    m_req[0] = 1'b1;
    step();
    n_vec++; if ({s_req, s_cmd} !== 2'b10) begin n_err++; $display("[TB] FAIL rd_sreq: got %b expected 10", {s_req, s_cmd}); end
    n_vec++; if (s_addr !== 32'h10) begin n_err++; $display("[TB] FAIL rd_saddr: got %h expected 00000010", s_addr); end
    step();
    step();
    n_vec++; if ({s_req, m_ack} !== 5'b10000) begin n_err++; $display("[TB] FAIL rd_wait: got %b expected 10000", {s_req, m_ack}); end
    s_ack = 1'b1; s_rdata = 32'hDEADBEEF;
    step();
    s_ack = 1'b0; s_rdata = 32'h0;
    n_vec++; if ({m_ack, s_req} !== 5'b00010) begin n_err++; $display("[TB] FAIL rd_ack: got %b expected 00010", {m_ack, s_req}); end
    n_vec++; if (m_rdata !== 32'hDEADBEEF) begin n_err++; $display("[TB] FAIL rd_rdata: got %h expected deadbeef", m_rdata); end
    step();
    n_vec++; if ({grant, m_ack} !== 8'b0001_0001) begin n_err++; $display("[TB] FAIL rd_hold: got %b expected 00010001", {grant, m_ack}); end
    m_req = '0; want = '0;
    step();
    n_vec++; if ({grant, m_ack, busy} !== 9'b0) begin n_err++; $display("[TB] FAIL rd_release: got %b expected 0", {grant, m_ack, busy}); end
  endtask

  task automatic test_round_robin();
    logic [31:0] sa, rd;
    logic sc, sr;
    logic [3:0] ack;
    logic [3:0] exp_g;
    int e;
    do_reset();
    want = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      e = k % N;
      exp_g = 4'b0001 << e;
      m_req = 4'b1111;
      step();
      n_vec++; if (grant !== exp_g || owner !== 2'(e)) begin n_err++; $display("[TB] FAIL rr_grant%0d: got %b/%0d expected %b/%0d", k, grant, owner, exp_g, e); end
      m_req = 4'b1111 & ~exp_g;
      set_master(0, 32'h100, 32'hA0, 1'b0);
      set_master(1, 32'h101, 32'hA1, 1'b1);
      set_master(2, 32'h102, 32'hA2, 1'b0);
      set_master(3, 32'h103, 32'hA3, 1'b1);
      run_xfer(e, 32'hC0DE0000 + 32'(e), sa, sc, sr, ack, rd);
      n_vec++; if ({sr, sc, sa} !== {1'b1, 1'(e % 2), 32'h100 + 32'(e)}) begin n_err++; $display("[TB] FAIL rr_slave%0d: got %b %b %h expected 1 %0d %h", k, sr, sc, sa, e % 2, 32'h100 + 32'(e)); end
      n_vec++; if (ack !== exp_g || rd !== 32'hC0DE0000 + 32'(e)) begin n_err++; $display("[TB] FAIL rr_ack%0d: got %b %h expected %b %h", k, ack, rd, exp_g, 32'hC0DE0000 + 32'(e)); end
      n_vec++; if (grant !== 4'b0) begin n_err++; $display("[TB] FAIL rr_gap%0d: got %b expected 0000", k, grant); end
    end
    want = '0; m_req = '0;
  endtask

  task automatic test_abandon();
    do_reset();
    want = 4'b0100;
    step();
    n_vec++; if ({grant, owner} !== {4'b0100, 2'd2}) begin n_err++; $display("[TB] FAIL ab_grant: got %b expected 010010", {grant, owner}); end
    want = 4'b1010;
    step();
    n_vec++; if ({grant, s_req, busy} !== 6'b0) begin n_err++; $display("[TB] FAIL ab_drop: got %b expected 000000", {grant, s_req, busy}); end
    step();
    n_vec++; if ({grant, owner} !== {4'b1000, 2'd3}) begin n_err++; $display("[TB] FAIL ab_next: got %b expected 100011", {grant, owner}); end
    want = '0;
    step();
  endtask

  task automatic test_write_isolation();
    do_reset();
    set_master(3, 32'h20, 32'h55AA, 1'b1);
    set_master(1, 32'h99, 32'h1234, 1'b0);
    m_req = 4'b0010;
    step();
    n_vec++; if ({s_req, busy, grant} !== 6'b0) begin n_err++; $display("[TB] FAIL wr_idle_ignore: got %b expected 000000", {s_req, busy, grant}); end
    want = 4'b1000; m_req = 4'b0000;
    step();
    n_vec++; if (grant !== 4'b1000) begin n_err++; $display("[TB] FAIL wr_grant: got %b expected 1000", grant); end
    s_ack = 1'b1;
    step();
    s_ack = 1'b0;
    n_vec++; if ({m_ack, s_req, busy} !== 6'b000001) begin n_err++; $display("[TB] FAIL wr_stray_ack: got %b expected 000001", {m_ack, s_req, busy}); end
    m_req = 4'b1010;
    step();
    n_vec++; if ({s_req, s_cmd, s_addr, s_data} !== {2'b11, 32'h20, 32'h55AA}) begin n_err++; $display("[TB] FAIL wr_slave: got %b %b %h %h expected 1 1 20 55aa", s_req, s_cmd, s_addr, s_data); end
    m_req = 4'b1000;
    step();
    m_req = 4'b1010;
    n_vec++; if ({s_req, s_cmd, s_addr} !== {2'b11, 32'h20}) begin n_err++; $display("[TB] FAIL wr_toggle: got %b %b %h expected 1 1 20", s_req, s_cmd, s_addr); end
    s_ack = 1'b1;
    step();
    s_ack = 1'b0;
    n_vec++; if (m_ack !== 4'b1000) begin n_err++; $display("[TB] FAIL wr_ack: got %b expected 1000", m_ack); end
    m_req = '0; want = '0;
    step();
    n_vec++; if ({grant, m_ack} !== 8'b0) begin n_err++; $display("[TB] FAIL wr_release: got %b expected 0", {grant, m_ack}); end
  endtask

  task automatic test_timeout();
    do_reset();
    want = 4'b0011;
    step();
    n_vec++; if (grant !== 4'b0001) begin n_err++; $display("[TB] FAIL to_grant: got %b expected 0001", grant); end
    set_master(0, 32'h40, 32'h0, 1'b0);
    m_req = 4'b0001;
    step();
    n_vec++; if (s_req !== 1'b1) begin n_err++; $display("[TB] FAIL to_xfer: got %b expected 1", s_req); end
`ifdef ARB_TIMEOUT_EN
    for (int t = 1; t <= 14; t++) begin
      step();
      n_vec++; if ({err, s_req} !== 2'b01) begin n_err++; $display("[TB] FAIL to_wait%0d: got %b expected 01", t, {err, s_req}); end
    end
    step();
    n_vec++; if ({err, grant, s_req, busy} !== 7'b1000000) begin n_err++; $display("[TB] FAIL to_fire: got %b expected 1000000", {err, grant, s_req, busy}); end
    step();
    n_vec++; if ({err, grant} !== 5'b00010) begin n_err++; $display("[TB] FAIL to_next: got %b expected 00010", {err, grant}); end
`else
    repeat (20) step();
    n_vec++; if ({s_req, busy, err, grant} !== 7'b1100001) begin n_err++; $display("[TB] FAIL to_stuck: got %b expected 1100001", {s_req, busy, err, grant}); end
`endif
    do_reset();
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_round_robin();
    test_abandon();
    test_write_isolation();
    test_timeout();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
